// File: rtl/alu_exec_unit.sv
// alu_exec_unit: MIPS-style ALU with single-cycle ops plus iterative mult/div writing HI/LO.
// Define ALU_EXEC_DIV_EN to build the restoring divider; without it div/divu decode as illegal.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             valid_out,
    output logic             busy,
    output logic             illegal
);
    localparam int LUI_SH = (WIDTH >= 32) ? 16 : WIDTH / 2;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0]   hi, lo;
    logic [SHW-1:0]     cnt;
    logic               last_iter;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_ill;
    logic               is_mul, is_div, is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod, mcand, prod_fin;
    logic [WIDTH-1:0]   mplier;
    logic               neg_q;

`ifdef ALU_EXEC_DIV_EN
    logic [WIDTH-1:0]   rem, quo, dvs, a_hold;
    logic               neg_r, div_zero, op_div;
    logic [WIDTH:0]     trial;
    logic               trial_ge;
    logic [WIDTH-1:0]   trial_diff;
`endif

    // Operation decode and single-cycle result; mult/div only raise their flags here.
    always_comb begin
        sc_res    = '0;
        sc_ill    = 1'b0;
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        case (alu_op)
            2'b00: sc_res = a + b;
            2'b01: sc_res = a - b;
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: sc_res = a + b;
                    6'b100010, 6'b100011: sc_res = a - b;
                    6'b100100: sc_res = a & b;
                    6'b100101: sc_res = a | b;
                    6'b100110: sc_res = a ^ b;
                    6'b100111: sc_res = ~(a | b);
                    6'b101010: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    6'b101011: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
                    6'b000000: sc_res = b << shamt;
                    6'b000010: sc_res = b >> shamt;
                    6'b000011: sc_res = $unsigned($signed(b) >>> shamt);
                    6'b010000: sc_res = hi;
                    6'b010010: sc_res = lo;
                    6'b011000: begin
                        is_mul    = 1'b1;
                        is_signed = 1'b1;
                    end
                    6'b011001: is_mul = 1'b1;
`ifdef ALU_EXEC_DIV_EN
                    6'b011010: begin
                        is_div    = 1'b1;
                        is_signed = 1'b1;
                    end
                    6'b011011: is_div = 1'b1;
`endif
                    default:   sc_ill = 1'b1;
                endcase
            end
            default: begin
                case (funct)
                    6'b001000, 6'b001001: sc_res = a + b;
                    6'b001010: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    6'b001100: sc_res = a & b;
                    6'b001101: sc_res = a | b;
                    6'b001110: sc_res = a ^ b;
                    6'b001111: sc_res = b << LUI_SH;
                    default:   sc_ill = 1'b1;
                endcase
            end
        endcase
    end

    // Iterative units work on magnitudes; signs are reapplied when the result is written back.
    assign a_neg     = is_signed & a[WIDTH-1];
    assign b_neg     = is_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign prod_fin  = neg_q ? -prod : prod;
    assign last_iter = (cnt == SHW'(WIDTH - 1));
    assign busy      = (state != IDLE);

`ifdef ALU_EXEC_DIV_EN
    assign trial      = {rem, quo[WIDTH-1]};
    assign trial_ge   = (trial >= {1'b0, dvs});
    assign trial_diff = trial[WIDTH-1:0] - dvs;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start && is_mul)      state_nx = MUL;
                else if (start && is_div) state_nx = DIV;
            end
            MUL, DIV: if (last_iter) state_nx = DONE;
            default:  state_nx = IDLE;
        endcase
    end

    // Datapath: result/flags, iteration registers, and HI/LO writeback in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            zero      <= 1'b0;
            valid_out <= 1'b0;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            neg_q     <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            a_hold    <= '0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            op_div    <= 1'b0;
`endif
        end else begin
            valid_out <= 1'b0;
            illegal   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        if (is_mul) begin
                            prod   <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a_mag};
                            mplier <= b_mag;
                            neg_q  <= a_neg ^ b_neg;
`ifdef ALU_EXEC_DIV_EN
                            op_div <= 1'b0;
                        end else if (is_div) begin
                            rem      <= '0;
                            quo      <= a_mag;
                            dvs      <= b_mag;
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            div_zero <= (b == '0);
                            a_hold   <= a;
                            op_div   <= 1'b1;
`endif
                        end else begin
                            result    <= sc_res;
                            zero      <= (sc_res == '0);
                            valid_out <= 1'b1;
                            illegal   <= sc_ill;
                        end
                    end
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
`ifdef ALU_EXEC_DIV_EN
                DIV: begin
                    rem <= trial_ge ? trial_diff : trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], trial_ge};
                    cnt <= cnt + 1'b1;
                end
`endif
                DONE: begin
                    result    <= '0;
                    zero      <= 1'b1;
                    valid_out <= 1'b1;
                    cnt       <= '0;
`ifdef ALU_EXEC_DIV_EN
                    if (op_div) begin
                        if (div_zero) begin
                            lo <= '1;
                            hi <= a_hold;
                        end else begin
                            lo <= neg_q ? -quo : quo;
                            hi <= neg_r ? -rem : rem;
                        end
                    end else
`endif
                    begin
                        hi <= prod_fin[2*WIDTH-1:WIDTH];
                        lo <= prod_fin[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH): shift-amount width.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  issue request; accepted only when busy=0.
REQ-006 SHALL have port alu_op  in  2  00 add, 01 sub, 10 R-type (decode funct), 11 I-type (decode funct as opcode).
REQ-007 SHALL have port funct  in  6  MIPS funct field, or opcode when alu_op=11.
REQ-008 SHALL have ports a, b  in  WIDTH  operands; b carries the extended immediate for I-type.
REQ-009 SHALL have port shamt  in  SHW  shift amount.
REQ-010 SHALL have port result  out  WIDTH  registered result.
REQ-011 SHALL have port zero  out  1  high when result==0, valid with valid_out.
REQ-012 SHALL have port valid_out  out  1  one-cycle completion pulse.
REQ-013 SHALL have port busy  out  1  high while a multi-cycle operation runs.
REQ-014 SHALL have port illegal  out  1  pulses with valid_out for undefined encodings.

Function
REQ-015 SHALL decode single-cycle ops: 00 add; 01 sub; R-type add/addu, sub/subu, and, or, xor, nor, slt (signed), sltu (unsigned), sll, srl, sra; I-type addi/addiu, andi, ori, xori, slti, lui (b<<16; for WIDTH<32, b<<(WIDTH/2)).
REQ-016 SHALL, for single-cycle ops, capture start in cycle N and assert valid_out with result in cycle N+1; busy stays 0.
REQ-017 SHALL compute add/sub modulo 2^WIDTH with no overflow trap.
REQ-018 SHALL implement R-type mult 011000, multu 011001, div 011010, divu 011011 as multi-cycle ops writing internal HI/LO; result is 0 for these ops.
REQ-019 SHALL implement mfhi 010000 and mflo 010010 as single-cycle reads of HI/LO.
REQ-020 SHALL use FSM states IDLE, MUL, DIV, DONE: IDLE->MUL/DIV on accepted start with a mul/div funct; MUL/DIV->DONE after exactly WIDTH iteration cycles; DONE->IDLE unconditionally, pulsing valid_out.
REQ-021 SHALL hold busy=1 from the cycle after acceptance through DONE inclusive; total latency WIDTH+2 cycles from start to valid_out.
REQ-022 SHALL implement mult as iterative shift-add on operand magnitudes, negating the 2*WIDTH product when operand signs differ; HI=upper half, LO=lower half.
REQ-023 SHALL implement div as restoring division on magnitudes; LO=quotient, HI=remainder; quotient negated if signs differ, remainder takes the dividend's sign.
REQ-024 SHALL, on divide by zero, produce LO=all ones and HI=a, with normal latency and no illegal pulse.
REQ-025 SHALL produce LO=most-negative value and HI=0 for signed most-negative / -1.
REQ-026 SHALL ignore start while busy=1; operands and HI/LO stay unaffected.
REQ-027 SHALL, for any undefined encoding, return result=0 and illegal=1 with valid_out at N+1; HI/LO unchanged.
REQ-028 SHALL update HI/LO only in the DONE cycle.

Reset
REQ-029 SHALL, on rst_n=0, immediately force state=IDLE, result=0, zero=0, valid_out=0, busy=0, illegal=0, HI=LO=0, and iteration counter=0, including mid-operation; an aborted operation produces no valid_out.
REQ-030 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL, when ALU_EXEC_DIV_EN is defined, include div/divu per REQ-020 to REQ-025.
REQ-032 SHALL, when ALU_EXEC_DIV_EN is undefined, synthesise no divider; div/divu are then treated as illegal per REQ-027, and mult, multu, mfhi and mflo are unaffected.

Verification
REQ-033 SHALL cover: alu_op=10, funct=100010, a=5, b=5 -> valid_out at N+1, result=0, zero=1.
REQ-034 SHALL cover: alu_op=10, funct=101010, a=0xFFFFFFFF, b=1 -> result=1; same operands with funct=101011 -> result=0.
REQ-035 SHALL cover: mult a=-3, b=7 -> busy for 33 cycles, valid_out at N+34; mflo=0xFFFFFFEB, mfhi=0xFFFFFFFF.
REQ-036 SHALL cover: div a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu a=9, b=0 -> LO=0xFFFFFFFF, HI=9 (ALU_EXEC_DIV_EN defined); with the macro undefined, div -> illegal=1 at N+1.
REQ-037 SHALL cover: start pulsed during busy -> ignored, with HI/LO matching the first operation only.
REQ-038 SHALL cover: rst_n asserted mid-mult -> outputs 0 immediately, no valid_out; a subsequent add 2+3 -> result=5 at N+1.
